// File: rtl/lcd_sensor_formatter_pkg.sv
// lcd_sensor_formatter_pkg: shared ASCII codes, FSM states and BCD width helper
package lcd_sensor_formatter_pkg;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_STAR  = 8'h2A;
   localparam logic [7:0] ASCII_DASH  = 8'h2D;
   typedef enum logic [2:0] {IDLE, CAPTURE, CONVERT, START, WAIT_DONE} state_t;
   function automatic int bcd_digits(input int w);
      int n;
      longint lim;
      n = 1;
      lim = 10;
      while (lim < (longint'(1) << w)) begin
         n++;
         lim *= 10;
      end
      return n;
   endfunction
endpackage

// File: rtl/lcd_sensor_formatter_if.sv
// lcd_sensor_formatter_if: sensor inputs, LCD rows and frame handshake
interface lcd_sensor_formatter_if #(parameter int NUM_CH = 2, parameter int VAL_W = 16);
   logic [NUM_CH*VAL_W-1:0] values;
   logic [NUM_CH-1:0]       ch_valid;
   logic                    update;
   logic                    lcd_done;
   logic [127:0]            row1;
   logic [127:0]            row2;
   logic                    frame_start;
   logic                    busy;
   logic                    timeout_err;
   logic [15:0]             frame_count;
   modport master (output values, ch_valid, update, lcd_done,
                   input row1, row2, frame_start, busy, timeout_err, frame_count);
   modport slave (input values, ch_valid, update, lcd_done,
                  output row1, row2, frame_start, busy, timeout_err, frame_count);
endinterface

// File: rtl/lcd_sensor_formatter_bin2bcd_serial.sv
// lcd_sensor_formatter_bin2bcd_serial: double-dabble, one input bit per cycle
module lcd_sensor_formatter_bin2bcd_serial
   import lcd_sensor_formatter_pkg::*;
#(
   parameter int VAL_W = 16,
   parameter int ND = bcd_digits(VAL_W)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [VAL_W-1:0] din,
   output logic [4*ND-1:0]  bcd,
   output logic             done
);
   localparam int CW = $clog2(VAL_W + 1);
   logic [VAL_W-1:0] bin_q, bin_d;
   logic [4*ND-1:0]  bcd_q, bcd_d, adj;
   logic [CW-1:0]    cnt_q, cnt_d;
   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < ND; i++)
         adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
      bin_d = load ? din : cnt_q != 0 ? {bin_q[VAL_W-2:0], 1'b0} : bin_q;
      bcd_d = load ? '0 : cnt_q != 0 ? {adj[4*ND-2:0], bin_q[VAL_W-1]} : bcd_q;
      cnt_d = load ? CW'(VAL_W) : cnt_q != 0 ? cnt_q - 1'b1 : cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
      end else begin
         bin_q <= bin_d;
         bcd_q <= bcd_d;
         cnt_q <= cnt_d;
      end
   assign bcd = bcd_q;
   assign done = cnt_q == 0;
endmodule

// File: rtl/lcd_sensor_formatter.sv
// lcd_sensor_formatter: snapshots sensor channels and builds two 16-char LCD rows per frame
module lcd_sensor_formatter
   import lcd_sensor_formatter_pkg::*;
#(
   parameter int                  NUM_CH       = 2,
   parameter int                  VAL_W        = 16,
   parameter int                  DIGITS       = 3,
   parameter logic [NUM_CH*32-1:0] LABELS      = "HR: O2: ",
   parameter int                  LZ_BLANK     = 1,
   parameter int                  REFRESH_CYC  = 0,
   parameter int                  DONE_TIMEOUT = 100000
) (
   input logic                clk_1MHz,
   input logic                rst_n,
   lcd_sensor_formatter_if.slave bus
);
   localparam int ND = bcd_digits(VAL_W);
   localparam int NE = ND + 4;
   localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam logic [255:0] BLANK = {32{ASCII_SPACE}};
   state_t                  state_q, state_d;
   logic [NUM_CH*VAL_W-1:0] vals_q, vals_d;
   logic [NUM_CH-1:0]       valid_q, valid_d;
   logic [CW-1:0]           ch_q, ch_d;
   logic [255:0]            work_q, work_d, rows_q, rows_d;
   logic                    pending_q, pending_d, frame_start_q, frame_start_d;
   logic                    busy_q, busy_d, timeout_err_q, timeout_err_d;
   logic [15:0]             frame_count_q, frame_count_d;
   logic [31:0]             refresh_q, refresh_d, wait_q, wait_d;
   logic                    load, done, req, tick;
   logic [VAL_W-1:0]        din;
   logic [4*ND-1:0]         bcd;
   logic [63:0]             field;
   lcd_sensor_formatter_bin2bcd_serial #(.VAL_W(VAL_W), .ND(ND)) u_bcd (
      .clk(clk_1MHz), .rst_n(rst_n), .load(load), .din(din), .bcd(bcd), .done(done)
   );
   always_comb begin
      logic [4*NE-1:0] dig;
      logic ovf, lead;
      dig = (4*NE)'(bcd);
      ovf = 1'b0;
      for (int d = DIGITS; d < ND; d++) ovf = ovf | (dig[4*d +: 4] != 4'd0);
      field = {LABELS[NUM_CH*32-1 - 32*int'(ch_q) -: 32], {4{ASCII_SPACE}}};
      lead = 1'b1;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         lead = lead && dig[4*d +: 4] == 4'd0 && d != 0;
         field[31 - 8*(DIGITS-1-d) -: 8] = !valid_q[ch_q] ? ASCII_DASH : ovf ? ASCII_STAR :
            lead && LZ_BLANK != 0 ? ASCII_SPACE : ASCII_ZERO + {4'd0, dig[4*d +: 4]};
      end
   end
   always_comb begin
      state_d = state_q;
      vals_d = vals_q;
      valid_d = valid_q;
      ch_d = ch_q;
      work_d = work_q;
      rows_d = rows_q;
      pending_d = pending_q;
      frame_start_d = 1'b0;
      timeout_err_d = 1'b0;
      frame_count_d = frame_count_q;
      wait_d = wait_q;
      load = 1'b0;
      tick = REFRESH_CYC != 0 && refresh_q == 32'(REFRESH_CYC - 1);
      refresh_d = tick || REFRESH_CYC == 0 ? '0 : refresh_q + 32'd1;
      req = bus.update || tick;
      // channel 0 loads straight from the inputs; later channels load during the previous field write
      din = state_q == CAPTURE ? bus.values[VAL_W-1:0] : vals_q[VAL_W*(int'(ch_q)+1) +: VAL_W];
      case (state_q)
         IDLE: if (req || pending_q) begin
            state_d = CAPTURE;
            pending_d = 1'b0;
         end
         CAPTURE: begin
            vals_d = bus.values;
            valid_d = bus.ch_valid;
            work_d = BLANK;
            ch_d = '0;
            load = 1'b1;
            state_d = CONVERT;
         end
         CONVERT: if (done) begin
            work_d[255 - 64*int'(ch_q) -: 64] = field;
            ch_d = ch_q + 1'b1;
            load = int'(ch_q) != NUM_CH - 1;
            state_d = int'(ch_q) == NUM_CH - 1 ? START : CONVERT;
         end
         START: begin
            rows_d = work_q;
            frame_start_d = 1'b1;
            wait_d = '0;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: if (bus.lcd_done) begin
            frame_count_d = frame_count_q + 16'd1;
            state_d = IDLE;
         end else if (wait_q == 32'(DONE_TIMEOUT - 1)) begin
            timeout_err_d = 1'b1;
            state_d = IDLE;
         end else wait_d = wait_q + 32'd1;
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE && req) pending_d = 1'b1;
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk_1MHz or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         vals_q <= '0;
         valid_q <= '0;
         ch_q <= '0;
         work_q <= BLANK;
         rows_q <= BLANK;
         pending_q <= 1'b0;
         frame_start_q <= 1'b0;
         busy_q <= 1'b0;
         timeout_err_q <= 1'b0;
         frame_count_q <= '0;
         refresh_q <= '0;
         wait_q <= '0;
      end else begin
         state_q <= state_d;
         vals_q <= vals_d;
         valid_q <= valid_d;
         ch_q <= ch_d;
         work_q <= work_d;
         rows_q <= rows_d;
         pending_q <= pending_d;
         frame_start_q <= frame_start_d;
         busy_q <= busy_d;
         timeout_err_q <= timeout_err_d;
         frame_count_q <= frame_count_d;
         refresh_q <= refresh_d;
         wait_q <= wait_d;
      end
   assign bus.row1 = rows_q[255:128];
   assign bus.row2 = rows_q[127:0];
   assign bus.frame_start = frame_start_q;
   assign bus.busy = busy_q;
   assign bus.timeout_err = timeout_err_q;
   assign bus.frame_count = frame_count_q;
endmodule

// File: tb/tb_lcd_sensor_formatter.sv
// tb_lcd_sensor_formatter: table, random and corner-sequence checks for three formatter configs
module tb_lcd_sensor_formatter;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst0_n, rst1_n, rst2_n;
   lcd_sensor_formatter_if #(.NUM_CH(2), .VAL_W(16)) if0 ();
   lcd_sensor_formatter_if #(.NUM_CH(2), .VAL_W(16)) if1 ();
   lcd_sensor_formatter_if #(.NUM_CH(2), .VAL_W(16)) if2 ();
   lcd_sensor_formatter u0 (.clk_1MHz(clk), .rst_n(rst0_n), .bus(if0));
   lcd_sensor_formatter #(.LZ_BLANK(0), .DONE_TIMEOUT(50)) u1 (.clk_1MHz(clk), .rst_n(rst1_n), .bus(if1));
   lcd_sensor_formatter #(.REFRESH_CYC(200)) u2 (.clk_1MHz(clk), .rst_n(rst2_n), .bus(if2));
   localparam logic [127:0] SP = {16{8'h20}};
   int checks = 0, errors = 0;
   typedef struct {
      int v0;
      int v1;
      logic [1:0] vld;
      logic [127:0] r1;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model_field(input logic [31:0] label, input int v, input bit vld, input bit lz);
      logic [63:0] f;
      int p;
      f = {label, {4{8'h20}}};
      for (int k = 0; k < 3; k++) begin
         p = 10 ** (2 - k);
         f[31-8*k -: 8] = !vld ? 8'h2D : v >= 1000 ? 8'h2A : (lz && k < 2 && v < p) ? 8'h20 : 8'(48 + (v / p) % 10);
      end
      return f;
   endfunction

   function automatic logic [127:0] model_row1(input int v0, input int v1, input logic [1:0] vld, input bit lz);
      return {model_field("HR: ", v0, vld[0], lz), model_field("O2: ", v1, vld[1], lz)};
   endfunction

   task automatic frame0(input int v0, input int v1, input logic [1:0] vld, output int lat);
      @(negedge clk);
      if0.values = {16'(v1), 16'(v0)};
      if0.ch_valid = vld;
      if0.update = 1'b1;
      @(negedge clk);
      if0.update = 1'b0;
      lat = 0;
      while (!if0.frame_start && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic done0();
      if0.lcd_done = 1'b1;
      @(negedge clk);
      if0.lcd_done = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, k, extra, v0, v1;
      logic [1:0] vld;
      int ts[$];
      tbl[0] = '{72, 98, 2'b11, "HR:  72 O2:  98 "};
      tbl[1] = '{1234, 5, 2'b11, "HR: *** O2:   5 "};
      tbl[2] = '{0, 999, 2'b11, "HR:   0 O2: 999 "};
      tbl[3] = '{7, 1234, 2'b01, "HR:   7 O2: --- "};
      tbl[4] = '{1000, 100, 2'b10, "HR: --- O2: 100 "};
      tbl[5] = '{65535, 10, 2'b11, "HR: *** O2:  10 "};
      {if0.values, if0.ch_valid, if0.update, if0.lcd_done} = '0;
      {if1.values, if1.ch_valid, if1.update, if1.lcd_done} = '0;
      {if2.values, if2.ch_valid, if2.update, if2.lcd_done} = '0;
      rst0_n = 1'b0;
      rst1_n = 1'b0;
      rst2_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_row1", if0.row1, SP);
      chk("reset_row2", if0.row2, SP);
      chk("reset_busy", 128'(if0.busy), 0);
      chk("reset_frame_start", 128'(if0.frame_start), 0);
      chk("reset_frame_count", 128'(if0.frame_count), 0);
      chk("reset_timeout_err", 128'(if1.timeout_err), 0);
      rst0_n = 1'b1;
      // two requests while waiting for lcd_done collapse into one follow-up frame
      frame0(72, 98, 2'b11, lat);
      chk("first_latency", 128'(lat), 36);
      chk("first_row1", if0.row1, "HR:  72 O2:  98 ");
      chk("first_row2", if0.row2, SP);
      @(negedge clk) if0.update = 1'b1;
      @(negedge clk) if0.update = 1'b0;
      @(negedge clk) if0.update = 1'b1;
      @(negedge clk) if0.update = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy_wait_done", 128'(if0.busy), 1);
      done0();
      k = 0;
      while (!if0.frame_start && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("pending_latency", 128'(k), 37);
      chk("pending_count1", 128'(if0.frame_count), 1);
      done0();
      chk("pending_count2", 128'(if0.frame_count), 2);
      extra = 0;
      repeat (80) begin
         @(negedge clk);
         if (if0.frame_start) extra++;
      end
      chk("pending_single", 128'(extra), 0);
      chk("idle_busy", 128'(if0.busy), 0);
      for (int i = 0; i < 6; i++) begin
         frame0(tbl[i].v0, tbl[i].v1, tbl[i].vld, lat);
         chk($sformatf("tbl%0d_latency", i), 128'(lat), 36);
         chk($sformatf("tbl%0d_row1", i), if0.row1, tbl[i].r1);
         chk($sformatf("tbl%0d_row2", i), if0.row2, SP);
         done0();
         chk($sformatf("tbl%0d_pulse", i), 128'(if0.frame_start), 0);
      end
      for (int i = 0; i < 20; i++) begin
         v0 = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 1100));
         v1 = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 1100));
         vld = 2'($urandom_range(0, 3));
         frame0(v0, v1, vld, lat);
         chk($sformatf("rnd%0d_latency", i), 128'(lat), 36);
         chk($sformatf("rnd%0d_row1 v0=%0d v1=%0d vld=%b", i, v0, v1, vld), if0.row1, model_row1(v0, v1, vld, 1'b1));
         chk($sformatf("rnd%0d_row2", i), if0.row2, SP);
         done0();
      end
      chk("total_frame_count", 128'(if0.frame_count), 28);
      // reset in the middle of conversion must abort without a frame
      @(negedge clk);
      if0.values = {16'd5, 16'd6};
      if0.ch_valid = 2'b11;
      if0.update = 1'b1;
      @(negedge clk) if0.update = 1'b0;
      repeat (10) @(negedge clk);
      rst0_n = 1'b0;
      @(negedge clk);
      chk("midreset_row1", if0.row1, SP);
      chk("midreset_row2", if0.row2, SP);
      chk("midreset_busy", 128'(if0.busy), 0);
      chk("midreset_count", 128'(if0.frame_count), 0);
      rst0_n = 1'b1;
      extra = 0;
      repeat (60) begin
         @(negedge clk);
         if (if0.frame_start) extra++;
      end
      chk("midreset_no_frame", 128'(extra), 0);
      // no leading-zero blanking, lcd_done never arrives
      rst1_n = 1'b1;
      @(negedge clk) if1.lcd_done = 1'b1;
      @(negedge clk) if1.lcd_done = 1'b0;
      @(negedge clk);
      chk("ignored_done", 128'(if1.frame_count), 0);
      if1.values = {16'd42, 16'd7};
      if1.ch_valid = 2'b11;
      if1.update = 1'b1;
      @(negedge clk) if1.update = 1'b0;
      lat = 0;
      while (!if1.frame_start && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("lz0_latency", 128'(lat), 36);
      chk("lz0_row1", if1.row1, "HR: 007 O2: 042 ");
      k = 0;
      while (!if1.timeout_err && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("timeout_delay", 128'(k), 50);
      chk("timeout_busy", 128'(if1.busy), 0);
      chk("timeout_count", 128'(if1.frame_count), 0);
      @(negedge clk);
      chk("timeout_pulse", 128'(if1.timeout_err), 0);
      // periodic refresh
      if2.values = {16'd5, 16'd123};
      if2.ch_valid = 2'b11;
      rst2_n = 1'b1;
      for (int t = 0; t < 800 && ts.size() < 3; t++) begin
         @(negedge clk);
         if2.lcd_done = 1'b0;
         if (if2.frame_start) begin
            ts.push_back(t);
            if2.lcd_done = 1'b1;
         end
      end
      @(negedge clk) if2.lcd_done = 1'b0;
      chk("refresh_frames", 128'(ts.size()), 3);
      if (ts.size() == 3) begin
         chk("refresh_period1", 128'(ts[1] - ts[0]), 200);
         chk("refresh_period2", 128'(ts[2] - ts[1]), 200);
      end
      chk("refresh_row1", if2.row1, "HR: 123 O2:   5 ");
      chk("refresh_count", 128'(if2.frame_count), 3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
